// File: rtl/lcd_bus_sequencer.sv
// Avalon-MM slave to HD44780 character-LCD bus sequencer: timed RS/RW/E cycles
// with automatic busy-flag polling after every write, stalling the fabric meanwhile.
`timescale 1ns/1ps
module lcd_bus_sequencer #(
    parameter int SETUP_CYC  = 2,
    parameter int E_HIGH_CYC = 12,
    parameter int HOLD_CYC   = 2,
    parameter int POLL_GAP   = 4,
    parameter int POLL_MAX   = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       waitrequest,
    output logic       timeout_err,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    inout  wire  [7:0] LCD_data
);

    localparam int MAX_A     = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
    localparam int MAX_B     = (HOLD_CYC > POLL_GAP) ? HOLD_CYC : POLL_GAP;
    localparam int STAGE_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW        = $clog2((STAGE_MAX > 2) ? STAGE_MAX : 2);
    localparam int PW        = $clog2((POLL_MAX > 2) ? POLL_MAX : 2);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    typedef enum logic [3:0] {
        IDLE, SETUP, EHIGH, HOLD, GAP, PSETUP, PEHIGH, PHOLD, DONE
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, stage_end;
    logic [PW-1:0] poll_cnt;
    logic [7:0]    data_q;
    logic          data_oe;
    logic          bf;
    logic          stage_last;
    logic          accept, poll_inc, timeout_set;
    logic          unused_addr0;

    assign unused_addr0 = address[0];
    assign LCD_data     = data_oe ? data_q : 8'hzz;
    assign waitrequest  = (read | write) & (state != DONE);

    // Untimed states use a length of one so the counter simply stays at zero.
    always_comb begin
        case (state)
            SETUP, PSETUP: stage_end = CW'(SETUP_CYC - 1);
            EHIGH, PEHIGH: stage_end = CW'(E_HIGH_CYC - 1);
            HOLD, PHOLD:   stage_end = CW'(HOLD_CYC - 1);
            GAP:           stage_end = CW'(POLL_GAP - 1);
            default:       stage_end = '0;
        endcase
    end

    assign stage_last = (cnt == stage_end);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        poll_inc    = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: if (read | write) begin
                accept     = 1'b1;
                state_next = SETUP;
            end
            SETUP:  if (stage_last) state_next = EHIGH;
            EHIGH:  if (stage_last) state_next = HOLD;
            HOLD:   if (stage_last) state_next = LCD_RW ? DONE : PSETUP;
            PSETUP: if (stage_last) state_next = PEHIGH;
            PEHIGH: if (stage_last) state_next = PHOLD;
            PHOLD: if (stage_last) begin
                if (!bf) begin
                    state_next = DONE;
                end else if (poll_cnt < POLL_LAST) begin
                    state_next = GAP;
                    poll_inc   = 1'b1;
                end else begin
                    state_next  = DONE;
                    timeout_set = 1'b1;
                end
            end
            GAP:     if (stage_last) state_next = PSETUP;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            poll_cnt    <= '0;
            LCD_E       <= 1'b0;
            LCD_RS      <= 1'b0;
            LCD_RW      <= 1'b1;
            data_q      <= '0;
            data_oe     <= 1'b0;
            readdata    <= '0;
            bf          <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= stage_last ? '0 : cnt + 1'b1;
            // E is registered from the next state so the pin is glitch-free and exact in width.
            LCD_E <= (state_next == EHIGH) || (state_next == PEHIGH);
            if (accept) begin
                LCD_RS   <= address[1];
                LCD_RW   <= read;
                data_q   <= writedata;
                data_oe  <= ~read;
                poll_cnt <= '0;
                if (write && !read) timeout_err <= 1'b0;
            end
            if (state == HOLD && stage_last && !LCD_RW) begin
                LCD_RS  <= 1'b0;
                LCD_RW  <= 1'b1;
                data_oe <= 1'b0;
            end
            if (state == EHIGH && stage_last && LCD_RW) readdata <= LCD_data;
            if (state == PEHIGH && stage_last) bf <= LCD_data[7];
            if (poll_inc) poll_cnt <= poll_cnt + 1'b1;
            if (timeout_set) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Self-checking bench for lcd_bus_sequencer: an LCD bus model with programmable busy
// flag, a per-transfer scoreboard of expected latency/readdata/poll count/timeout.
`timescale 1ns/1ps
module tb_lcd_bus_sequencer;

    localparam int T_CYC    = 16;
    localparam int E_HIGH   = 12;
    localparam int POLL_LOW = 8;
    localparam int BUDGET   = 2000;

    typedef struct {
        string      name;
        int         lat;
        int         pulses;
        logic [7:0] rd;
        logic       chk_rd;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] address = '0;
    logic [7:0] writedata = '0;
    logic       read0 = 1'b0, write0 = 1'b0, read1 = 1'b0, write1 = 1'b0;
    logic       sel = 1'b0;

    logic [7:0] readdata0, readdata1;
    logic       wait0, wait1, to0, to1;
    logic       lcd_e0, lcd_rs0, lcd_rw0, lcd_e1, lcd_rs1, lcd_rw1;
    wire  [7:0] lcd_data0, lcd_data1;

    // LCD model: drives the bus only while E is high with RW=1; undriven bus floats to 8'hFF.
    logic       model_read_mode = 1'b0;
    logic [7:0] rd_value = '0;
    int         polls_seen = 0;
    int         bf_base = 0;
    int         bf_polls = 0;
    logic [7:0] model_byte;

    always_comb model_byte = model_read_mode ? rd_value
                           : (((polls_seen - bf_base) < bf_polls) ? 8'h80 : 8'h00);

    assign lcd_data0 = (lcd_e0 && lcd_rw0) ? model_byte : 8'hzz;
    assign lcd_data1 = (lcd_e1 && lcd_rw1) ? model_byte : 8'hzz;

    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup pu0 (lcd_data0[i]);
        pullup pu1 (lcd_data1[i]);
    end

    wire       e_s    = sel ? lcd_e1 : lcd_e0;
    wire       rs_s   = sel ? lcd_rs1 : lcd_rs0;
    wire       rw_s   = sel ? lcd_rw1 : lcd_rw0;
    wire       wait_s = sel ? wait1 : wait0;
    wire       to_s   = sel ? to1 : to0;
    wire [7:0] rd_s   = sel ? readdata1 : readdata0;
    wire [7:0] bus_s  = sel ? lcd_data1 : lcd_data0;

    always @(negedge e_s) begin
        if (!model_read_mode && rw_s) polls_seen = polls_seen + 1;
    end

    always #10 clk = ~clk;

    lcd_bus_sequencer dut0 (
        .clk(clk), .reset(reset), .address(address), .read(read0), .write(write0),
        .writedata(writedata), .readdata(readdata0), .waitrequest(wait0),
        .timeout_err(to0), .LCD_E(lcd_e0), .LCD_RS(lcd_rs0), .LCD_RW(lcd_rw0),
        .LCD_data(lcd_data0)
    );

    lcd_bus_sequencer #(.POLL_MAX(3)) dut1 (
        .clk(clk), .reset(reset), .address(address), .read(read1), .write(write1),
        .writedata(writedata), .readdata(readdata1), .waitrequest(wait1),
        .timeout_err(to1), .LCD_E(lcd_e1), .LCD_RS(lcd_rs1), .LCD_RW(lcd_rw1),
        .LCD_data(lcd_data1)
    );

    task automatic set_model(input logic rd_mode, input logic [7:0] rdval, input int busy_polls);
        model_read_mode = rd_mode;
        rd_value        = rdval;
        bf_base         = polls_seen;
        bf_polls        = busy_polls;
    endtask

    task automatic do_xfer(input logic s, input logic rd, input logic wr, input logic [1:0] addr,
                           input logic [7:0] wdata, input int exp_lat, input int exp_polls,
                           input logic [7:0] exp_rd, input logic exp_to, input string name);
        exp_t e, got;
        int done_k = -1, pulses = 0, ehigh_run = 0, low_run = 0;
        int bad_e = 0, bad_ctl = 0, bad_bus = 0, bad_gap = 0;
        e.name = name; e.lat = exp_lat; e.pulses = exp_polls + 1;
        e.rd = exp_rd; e.chk_rd = rd; e.to = exp_to;
        sb.push_back(e);
        @(negedge clk);
        sel = s; address = addr; writedata = wdata;
        if (s) begin read1 = rd; write1 = wr; end
        else   begin read0 = rd; write0 = wr; end
        #1;
        checks++;
        if (wait_s !== 1'b1) $display("FAIL %s stall_cycle0: waitrequest=%b want 1", name, wait_s);
        else passed++;
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (e_s) begin
                if (ehigh_run == 0 && pulses >= 2 && low_run != POLL_LOW) bad_gap++;
                ehigh_run++;
                low_run = 0;
                if (pulses == 0) begin
                    if (rs_s !== addr[1] || rw_s !== rd) bad_ctl++;
                end else if (rs_s !== 1'b0 || rw_s !== 1'b1) bad_ctl++;
            end else begin
                if (ehigh_run > 0) begin
                    if (ehigh_run != E_HIGH) bad_e++;
                    pulses++;
                    ehigh_run = 0;
                end
                if (pulses > 0) low_run++;
            end
            if (!rd && k <= T_CYC) begin
                if (bus_s !== wdata) bad_bus++;
            end else if (!e_s && bus_s !== 8'hFF) bad_bus++;
            if (!wait_s) begin
                done_k = k;
                break;
            end
        end
        got = sb.pop_front();
        checks++;
        if (done_k < 0) begin
            $display("FAIL %s latency: waitrequest never dropped within %0d cycles", got.name, BUDGET);
        end else begin
            if (done_k !== got.lat) $display("FAIL %s latency: got %0d want %0d", got.name, done_k, got.lat);
            else passed++;
            checks++;
            if (pulses !== got.pulses) $display("FAIL %s e_pulses: got %0d want %0d", got.name, pulses, got.pulses);
            else passed++;
            checks++;
            if (to_s !== got.to) $display("FAIL %s timeout_err: got %b want %b", got.name, to_s, got.to);
            else passed++;
            if (got.chk_rd) begin
                checks++;
                if (rd_s !== got.rd) $display("FAIL %s readdata: got %h want %h", got.name, rd_s, got.rd);
                else passed++;
            end
            checks++;
            if (bad_e != 0 || bad_gap != 0)
                $display("FAIL %s e_timing: bad_width=%0d bad_gap=%0d want 0/0", got.name, bad_e, bad_gap);
            else passed++;
            checks++;
            if (bad_ctl != 0 || bad_bus != 0)
                $display("FAIL %s pins: bad_rs_rw=%0d bad_bus=%0d want 0/0", got.name, bad_ctl, bad_bus);
            else passed++;
        end
        read0 = 1'b0; write0 = 1'b0; read1 = 1'b0; write1 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (lcd_e0 !== 1'b0 || lcd_rs0 !== 1'b0 || lcd_rw0 !== 1'b1 || lcd_e1 !== 1'b0 || lcd_rw1 !== 1'b1)
            $display("FAIL reset_pins: e=%b rs=%b rw=%b e1=%b rw1=%b want 0 0 1 0 1",
                     lcd_e0, lcd_rs0, lcd_rw0, lcd_e1, lcd_rw1);
        else passed++;
        checks++;
        if (lcd_data0 !== 8'hFF || readdata0 !== 8'h00 || to0 !== 1'b0 || wait0 !== 1'b0)
            $display("FAIL reset_outputs: bus=%h readdata=%h to=%b wait=%b want FF 00 0 0",
                     lcd_data0, readdata0, to0, wait0);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_write_data();
        set_model(1'b0, 8'h00, 0);
        do_xfer(1'b0, 1'b0, 1'b1, 2'b10, 8'h41, 33, 1, 8'h00, 1'b0, "write_data");
    endtask

    task automatic test_busy_poll();
        set_model(1'b0, 8'h00, 3);
        do_xfer(1'b0, 1'b0, 1'b1, 2'b00, 8'h01, 93, 4, 8'h00, 1'b0, "busy_poll");
    endtask

    task automatic test_read();
        set_model(1'b1, 8'hA7, 0);
        do_xfer(1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 17, 0, 8'hA7, 1'b0, "read_status");
    endtask

    task automatic test_read_write_both();
        set_model(1'b1, 8'h3C, 0);
        do_xfer(1'b0, 1'b1, 1'b1, 2'b10, 8'h55, 17, 0, 8'h3C, 1'b0, "read_write_both");
    endtask

    task automatic test_back_to_back();
        set_model(1'b0, 8'h00, 0);
        do_xfer(1'b0, 1'b0, 1'b1, 2'b00, 8'h38, 33, 1, 8'h00, 1'b0, "b2b_write");
        set_model(1'b1, 8'h5E, 0);
        do_xfer(1'b0, 1'b1, 1'b0, 2'b10, 8'h00, 17, 0, 8'h5E, 1'b0, "b2b_read");
    endtask

    task automatic test_timeout();
        set_model(1'b0, 8'h00, 1000);
        do_xfer(1'b1, 1'b0, 1'b1, 2'b00, 8'h01, 73, 3, 8'h00, 1'b1, "timeout_write");
        set_model(1'b1, 8'h11, 0);
        do_xfer(1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 17, 0, 8'h11, 1'b1, "timeout_read_keeps");
        set_model(1'b0, 8'h00, 0);
        do_xfer(1'b1, 1'b0, 1'b1, 2'b10, 8'h20, 33, 1, 8'h00, 1'b0, "timeout_write_clears");
    endtask

    task automatic test_reset_mid();
        int seen_e = 0;
        int bad_wait = 0;
        set_model(1'b0, 8'h00, 0);
        @(negedge clk);
        sel = 1'b0; address = 2'b00; writedata = 8'h99; write0 = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (lcd_e0) begin
                seen_e = 1;
                break;
            end
        end
        checks++;
        if (seen_e == 0) $display("FAIL reset_mid_e_rise: LCD_E never rose within 50 cycles");
        else passed++;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (lcd_e0 !== 1'b0 || lcd_rw0 !== 1'b1 || lcd_rs0 !== 1'b0 || lcd_data0 !== 8'hFF)
            $display("FAIL reset_mid_pins: e=%b rw=%b rs=%b bus=%h want 0 1 0 FF",
                     lcd_e0, lcd_rw0, lcd_rs0, lcd_data0);
        else passed++;
        checks++;
        if (readdata0 !== 8'h00 || to0 !== 1'b0)
            $display("FAIL reset_mid_regs: readdata=%h to=%b want 00 0", readdata0, to0);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (wait0 !== 1'b1) bad_wait++;
        end
        checks++;
        if (bad_wait != 0) $display("FAIL reset_mid_wait: %0d cycles with waitrequest low, want 0", bad_wait);
        else passed++;
        write0 = 1'b0;
        reset  = 1'b0;
        do_xfer(1'b0, 1'b0, 1'b1, 2'b00, 8'h0C, 33, 1, 8'h00, 1'b0, "after_reset_write");
    endtask

    initial begin
        test_reset();
        test_write_data();
        test_busy_poll();
        test_read();
        test_read_write_both();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lcd_bus_sequencer.md
# lcd_bus_sequencer

Timed bus controller for the HD44780-compatible character LCD on the board, sitting between the Nios II Avalon-MM fabric and the LCD pins. It takes byte-wide register reads and writes from one Avalon slave port and turns each into a correctly timed LCD bus cycle: RS/RW setup, E pulse width, hold and bus turnaround. After every write it polls the LCD busy flag until clear, so software never needs delay loops. It stretches the Avalon transfer with `waitrequest` until the LCD cycle, including busy polling, is complete.

## Interface
- `SETUP_CYC`, 2: clocks RS/RW/data are stable before E rises (≥40 ns at 50 MHz).
- `E_HIGH_CYC`, 12: clocks E is held high (≥230 ns).
- `HOLD_CYC`, 2: clocks RS/RW/data are held after E falls.
- `POLL_GAP`, 4: idle clocks between consecutive busy-flag polls.
- `POLL_MAX`, 4096: maximum busy polls per write before timeout; ≥1.
- `clk`  in  1  system clock, 50 MHz nominal.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  in  2  bit1 = RS (0 instruction, 1 data); bit0 ignored, since RW comes from read/write.
- `read`  in  1  Avalon read request.
- `write`  in  1  Avalon write request.
- `writedata`  in  8  byte to write.
- `readdata`  out  8  byte captured from LCD; registered, valid when `waitrequest` is low.
- `waitrequest`  out  1  Avalon stall.
- `timeout_err`  out  1  sticky: a busy poll reached `POLL_MAX` with BF still 1.
- `LCD_E`, `LCD_RS`, `LCD_RW`  out  1  LCD control pins.
- `LCD_data`  inout  8  LCD data bus. Driven only during write cycles, otherwise high-Z.

## Operation
- States: IDLE, SETUP, EHIGH, HOLD, GAP, PSETUP, PEHIGH, PHOLD, DONE.
- IDLE: on `read|write` high, latch RS=`address[1]`, RW=`read`, and data=`writedata`, then go to SETUP. If `read` and `write` are both high, treat the transfer as a read.
- SETUP (`SETUP_CYC`) → EHIGH (`E_HIGH_CYC`, `LCD_E`=1) → HOLD (`HOLD_CYC`).
  - For a read, `LCD_data` is sampled into `readdata` on the last EHIGH clock.
  - After HOLD, a read goes to DONE and a write goes to PSETUP.
- Busy poll:
  - PSETUP/PEHIGH/PHOLD use the same counts with RS=0, RW=1.
  - BF = `LCD_data[7]`, sampled on the last PEHIGH clock.
  - After PHOLD: if BF=0, go to DONE. If BF=1 and the poll count is below `POLL_MAX`, go to GAP (`POLL_GAP` clocks, E low), then PSETUP. Otherwise set `timeout_err` and go to DONE.
- DONE: one clock, `waitrequest`=0, return to IDLE. The fabric must drop or renew its request in that cycle. A new request in the following IDLE clock starts a new cycle.
- `waitrequest` = (`read|write`) & ~(state==DONE), which is combinational.
- `timeout_err` is cleared by reset or by the next accepted write. It is not cleared by reads.
- RS/RW change only while E is low, at IDLE→SETUP or HOLD→PSETUP. The data bus is released (high-Z) in the same clock RW goes to 1.
- All stage counters and the poll counter are sized as clog2(max(param,2)). A parameter value of 0 is illegal.

## Timing
- Reset values (asynchronous, taking effect immediately, including mid-cycle): state IDLE, `LCD_E`=0, `LCD_RS`=0, `LCD_RW`=1, `LCD_data` high-Z, `readdata`=0, `timeout_err`=0, all counters 0.
- `LCD_E`, `LCD_RS` and `LCD_RW` come straight from registers (glitch-free). E is never high in SETUP, HOLD, GAP or IDLE.
- Let T = `SETUP_CYC`+`E_HIGH_CYC`+`HOLD_CYC` (16 by default). Counting from the first clock the request is high in IDLE, `waitrequest` goes low at clock:
  - read: T+1 = 17
  - write with first poll BF=0: 2T+1 = 33
  - each extra BF=1 poll adds `POLL_GAP`+T = 20.
- E high pulse = `E_HIGH_CYC` clocks exactly. Minimum E low between polls = `HOLD_CYC`+`POLL_GAP`+`SETUP_CYC`.
- Throughput: one LCD transfer in flight at a time. No buffering.

## Test plan
- Reset mid-EHIGH of a write → `LCD_E` falls the same cycle, `LCD_data` goes high-Z, `LCD_RW`=1, `waitrequest` follows request with no DONE; a fresh write afterwards completes normally in 33 clocks.
- Write address=2'b10, data 8'h41, LCD model BF=0 → RS=1, RW=0, data 8'h41 driven from SETUP through HOLD, E high 12 clocks, then one poll with RS=0/RW=1; `waitrequest` low at clock 33 for one cycle.
- Write 8'h01, model BF=1 for 3 polls then 0 → 4 polls, each gap exactly 4 clocks; `waitrequest` low at clock 33+3×20=93; `timeout_err`=0.
- Read address=2'b00, model drives 8'hA7 → RW=1, bus never driven by the DUT, `readdata`=8'hA7 when `waitrequest` drops at clock 17; no poll follows.
- `POLL_MAX`=3, model BF stuck at 1 → exactly 3 polls, then DONE and `timeout_err`=1. A subsequent read leaves it at 1; a subsequent write with BF=0 clears it to 0.
- `read` and `write` both high, address=2'b10 → read cycle (RW=1, RS=1), `writedata` ignored, completion at clock 17.
